interrupt_sequencer: RTL and testbench
======================================

Name: interrupt_sequencer

Overview:
- Multi-cycle sequencer that runs the 6502 reset, NMI, IRQ and BRK entry sequences on behalf of the main control FSM.
- It pushes PCH, PCL and P to the stack, fetches the vector, then hands the new PC and SP back to the main control FSM.
- It generalises the main control FSM's fixed reset-vector states in three ways: parametrised address width and vector/stack locations, memory wait-state support, and NMI hijack.
- Sits between the control FSM and the memory port; the control FSM yields the bus while busy=1.

Parameters:
ADDR_W, 16, address bus width (>= 9)
STACK_PAGE, 'h01, upper ADDR_W-8 bits of stack addresses
VEC_BASE, 'hFFFA, NMI vector address; RESET = VEC_BASE+2, IRQ/BRK = VEC_BASE+4

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  instruction-boundary strobe from control FSM
nmi  in  1  NMI line, rising-edge sensitive
irq  in  1  IRQ request, level
irq_mask  in  1  P.I flag
brk_req  in  1  BRK opcode decoded
pc_in  in  ADDR_W  current PC
p_in  in  8  current status register
sp_in  in  8  current stack pointer
mem_rdata  in  8  read data, valid when mem_ready=1
mem_ready  in  1  access completes this cycle
mem_en  out  1  memory access active
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  access address
mem_wdata  out  8  write data
busy  out  1  sequence in progress
int_pending  out  1  a source is pending, combinational
pc_out  out  ADDR_W  fetched vector
pc_load  out  1  one-cycle load strobe for PC
sp_out  out  8  final SP
sp_load  out  1  one-cycle load strobe for SP
set_int_disable  out  1  one-cycle strobe to set P.I

Behaviour:
- Async reset: state=IDLE, rst_pending=1, nmi_pending=0, all outputs 0.
- Reset asserted mid-sequence aborts immediately; no pc_load is issued.
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, DONE.
- int_pending = rst_pending | nmi_pending | brk_req | (irq & ~irq_mask).
- IDLE exit:
  - On the first clk after reset release, go to PUSH_PCH in reset mode regardless of start.
  - Otherwise go to PUSH_PCH when start & int_pending.
  - start with nothing pending: remain in IDLE with no strobes.
- Source priority at entry: RESET > NMI > BRK > IRQ. The source is latched.
  - nmi_pending clears on entry when NMI is selected.
  - rst_pending clears on entry in reset mode.
- NMI edge detect: nmi_pending is set on a 0->1 transition of nmi, sampled each clk. A set coinciding with a clear leaves it set.
- NMI hijack: an IRQ/BRK sequence with nmi_pending=1 on leaving PUSH_P switches to the NMI vector and clears nmi_pending. An NMI edge arriving in VEC_LO or later stays pending for the next start.
- Push states: mem_en=1, mem_we=1, mem_addr={STACK_PAGE, sp}, where sp starts at sp_in and decrements mod 256 after each completed access (0x00 -> 0xFF).
  - Write data: PCH = pc_in[ADDR_W-1:8], PCL = pc_in[7:0].
  - P write data = p_in | 0x20, with bit4 = 1 for BRK and 0 for IRQ/NMI.
  - Reset mode: mem_en=0 and mem_we=0, but sp still decrements, for 3 dummy cycles with no writes.
- VEC_LO / VEC_HI: mem_we=0, mem_addr = vector and vector+1; the byte is captured on mem_ready.
- Wait states: in any access state with mem_ready=0, hold state, mem_addr, mem_wdata and mem_we unchanged. Dummy reset-mode cycles do not wait for mem_ready.
- DONE (one cycle):
  - pc_out = {hi, lo}, sp_out = sp_in - 3 (mod 256).
  - pc_load, sp_load and set_int_disable are all 1; next state is IDLE.
- busy=1 in every state except IDLE. Outputs decode from registered state and datapath regs.
- Minimum latency, mem_ready always 1: six busy cycles from entry to DONE inclusive.

Test Plan:
- Reset release; mem[FFFC]=0x00, mem[FFFD]=0x80, sp_in=0x00 -> no writes; reads FFFC then FFFD; DONE on the 6th cycle; pc_out=0x8000, sp_out=0xFD.
- irq=1, irq_mask=0, start; pc_in=0x1234, p_in=0x00, sp_in=0xFF -> writes 01FF=0x12, 01FE=0x34, 01FD=0x20; reads FFFE/FFFF; sp_out=0xFC; set_int_disable pulses once.
- brk_req, p_in=0xC3, sp_in=0x01 -> writes 0101, 0100, then 01FF=0xF3 (SP wrap); sp_out=0xFE.
- irq=1, irq_mask=1, start -> stays IDLE, int_pending=0. Then nmi rising edge, start -> vector read from FFFA.
- NMI edge during PUSH_PCL of an IRQ sequence -> pushed P bit4=0, vector FFFA, nmi_pending=0 after. A second NMI edge during VEC_LO -> int_pending=1 after DONE.
- mem_ready=0 for 2 cycles in PUSH_PCL -> address/data held, 8 busy cycles total. Then reset asserted in VEC_HI -> outputs 0 at once, no pc_load; full reset sequence follows release.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: runs the reset / NMI / BRK / IRQ entry sequence.
// Three pushes (PCH, PCL, P) are followed by a two-byte vector fetch, then
// the new PC and SP are handed back to the control FSM with one-cycle load
// strobes. Reset mode performs dummy pushes: SP moves, nothing is written.
// An NMI that becomes pending before the P push completes takes over the
// vector of an IRQ/BRK sequence.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start with a pending source (or reset release)
// PUSH_PCH | write PC high byte to {STACK_PAGE, sp}
// PUSH_PCL | write PC low byte to {STACK_PAGE, sp}
// PUSH_P   | write status byte; NMI may take over the vector here
// VEC_LO   | read vector low byte
// VEC_HI   | read vector high byte
// DONE     | one cycle of pc_load / sp_load / set_int_disable
module interrupt_sequencer #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-9:0] STACK_PAGE = 'h01,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 'hFFFA
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              nmi_i,
    input  logic              irq_i,
    input  logic              irq_mask_i,
    input  logic              brk_req_i,
    input  logic [ADDR_W-1:0] pc_in_i,
    input  logic [7:0]        p_in_i,
    input  logic [7:0]        sp_in_i,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              busy_o,
    output logic              int_pending_o,
    output logic [ADDR_W-1:0] pc_out_o,
    output logic              pc_load_o,
    output logic [7:0]        sp_out_o,
    output logic              sp_load_o,
    output logic              set_int_disable_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_PCH,
        S_PUSH_PCL,
        S_PUSH_P,
        S_VEC_LO,
        S_VEC_HI,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_RESET,
        SRC_NMI,
        SRC_BRK,
        SRC_IRQ
    } src_t;

    localparam logic [ADDR_W-1:0] VEC_NMI = VEC_BASE;
    localparam logic [ADDR_W-1:0] VEC_RST = VEC_BASE + ADDR_W'(2);
    localparam logic [ADDR_W-1:0] VEC_IRQ = VEC_BASE + ADDR_W'(4);

    state_t            state_q;
    src_t              src_q;
    logic              rst_pending_q;
    logic              nmi_pending_q;
    logic              nmi_pending_d;
    logic              nmi_prev_q;
    logic [7:0]        sp_q;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        p_q;
    logic [ADDR_W-1:0] vec_q;
    logic [7:0]        lo_q;
    logic [7:0]        hi_q;

    logic              nmi_edge;
    logic              pend_any;
    logic              go;
    src_t              src_sel;
    logic [ADDR_W-1:0] vec_sel;
    logic              is_reset;
    logic              push_done;
    logic              hijack;
    logic              nmi_clr;
    logic [7:0]        pch;
    logic [7:0]        p_push;
    logic [15:0]       vec_word;

    assign nmi_edge = nmi_i & ~nmi_prev_q;
    assign pend_any = rst_pending_q | nmi_pending_q | brk_req_i | (irq_i & ~irq_mask_i);
    assign go       = rst_pending_q | (start_i & pend_any);
    assign is_reset = (src_q == SRC_RESET);
    // Dummy reset pushes never stall on the memory port.
    assign push_done = is_reset | mem_ready_i;
    assign hijack    = (state_q == S_PUSH_P) && push_done && nmi_pending_q &&
                       ((src_q == SRC_BRK) || (src_q == SRC_IRQ));
    assign nmi_clr   = ((state_q == S_IDLE) && go && (src_sel == SRC_NMI)) || hijack;
    // A new edge wins over a simultaneous clear so that NMI is never lost.
    assign nmi_pending_d = nmi_edge | (nmi_pending_q & ~nmi_clr);

    assign p_push   = (p_q & 8'hEF) | 8'h20 | ((src_q == SRC_BRK) ? 8'h10 : 8'h00);
    assign vec_word = {hi_q, lo_q};

    // Entry source priority and its vector.
    always_comb begin
        src_sel = SRC_IRQ;
        vec_sel = VEC_IRQ;
        if (rst_pending_q) begin
            src_sel = SRC_RESET;
            vec_sel = VEC_RST;
        end else if (nmi_pending_q) begin
            src_sel = SRC_NMI;
            vec_sel = VEC_NMI;
        end else if (brk_req_i) begin
            src_sel = SRC_BRK;
        end
    end

    // PC high byte, zero-filled for narrow address buses.
    always_comb begin
        pch = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i + 8 < ADDR_W) pch[i] = pc_q[i+8];
        end
    end

    // Sequencer state, pending flags and datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            src_q         <= SRC_RESET;
            rst_pending_q <= 1'b1;
            nmi_pending_q <= 1'b0;
            nmi_prev_q    <= 1'b0;
            sp_q          <= 8'h00;
            pc_q          <= '0;
            p_q           <= 8'h00;
            vec_q         <= '0;
            lo_q          <= 8'h00;
            hi_q          <= 8'h00;
        end else begin
            nmi_prev_q    <= nmi_i;
            nmi_pending_q <= nmi_pending_d;
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_q       <= S_PUSH_PCH;
                        src_q         <= src_sel;
                        vec_q         <= vec_sel;
                        sp_q          <= sp_in_i;
                        pc_q          <= pc_in_i;
                        p_q           <= p_in_i;
                        rst_pending_q <= 1'b0;
                    end
                end
                S_PUSH_PCH: begin
                    if (push_done) begin
                        sp_q    <= sp_q - 8'd1;
                        state_q <= S_PUSH_PCL;
                    end
                end
                S_PUSH_PCL: begin
                    if (push_done) begin
                        sp_q    <= sp_q - 8'd1;
                        state_q <= S_PUSH_P;
                    end
                end
                S_PUSH_P: begin
                    if (push_done) begin
                        sp_q    <= sp_q - 8'd1;
                        state_q <= S_VEC_LO;
                        if (hijack) vec_q <= VEC_NMI;
                    end
                end
                S_VEC_LO: begin
                    if (mem_ready_i) begin
                        lo_q    <= mem_rdata_i;
                        state_q <= S_VEC_HI;
                    end
                end
                S_VEC_HI: begin
                    if (mem_ready_i) begin
                        hi_q    <= mem_rdata_i;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output decode from registered state and datapath.
    always_comb begin
        mem_en_o          = 1'b0;
        mem_we_o          = 1'b0;
        mem_addr_o        = '0;
        mem_wdata_o       = 8'h00;
        busy_o            = (state_q != S_IDLE);
        int_pending_o     = ~reset_i & pend_any;
        pc_out_o          = '0;
        pc_load_o         = 1'b0;
        sp_out_o          = 8'h00;
        sp_load_o         = 1'b0;
        set_int_disable_o = 1'b0;
        case (state_q)
            S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
                mem_en_o   = ~is_reset;
                mem_we_o   = ~is_reset;
                mem_addr_o = {STACK_PAGE, sp_q};
                if (!is_reset) begin
                    if (state_q == S_PUSH_PCH)      mem_wdata_o = pch;
                    else if (state_q == S_PUSH_PCL) mem_wdata_o = pc_q[7:0];
                    else                            mem_wdata_o = p_push;
                end
            end
            S_VEC_LO: begin
                mem_en_o   = 1'b1;
                mem_addr_o = vec_q;
            end
            S_VEC_HI: begin
                mem_en_o   = 1'b1;
                mem_addr_o = vec_q + ADDR_W'(1);
            end
            S_DONE: begin
                pc_out_o          = ADDR_W'(vec_word);
                pc_load_o         = 1'b1;
                sp_out_o          = sp_q;
                sp_load_o         = 1'b1;
                set_int_disable_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: memory model, write/read/done scoreboards.
module tb_interrupt_sequencer;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset, start, nmi, irq, irq_mask, brk_req;
    logic [AW-1:0] pc_in;
    logic [7:0]    p_in, sp_in, mem_rdata;
    logic          mem_ready;
    logic          mem_en, mem_we, busy, int_pending, pc_load, sp_load, set_int_disable;
    logic [AW-1:0] mem_addr, pc_out;
    logic [7:0]    mem_wdata, sp_out;

    logic [7:0] mem [0:65535];

    typedef struct packed { logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [15:0] pc; logic [7:0] sp; } done_t;

    wr_t         wr_q[$];
    logic [15:0] rd_q[$];
    done_t       done_q[$];
    wr_t         exp_wr;
    logic [15:0] exp_rd;
    done_t       exp_done;

    int n_checks = 0;
    int n_fail   = 0;

    interrupt_sequencer #(.ADDR_W(16), .STACK_PAGE(8'h01), .VEC_BASE(16'hFFFA)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .nmi_i(nmi), .irq_i(irq),
        .irq_mask_i(irq_mask), .brk_req_i(brk_req), .pc_in_i(pc_in), .p_in_i(p_in),
        .sp_in_i(sp_in), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .busy_o(busy), .int_pending_o(int_pending), .pc_out_o(pc_out), .pc_load_o(pc_load),
        .sp_out_o(sp_out), .sp_load_o(sp_load), .set_int_disable_o(set_int_disable)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];

    // Scoreboard: completed accesses and DONE strobes against expected queues.
    always @(negedge clk) begin
        if (!reset && mem_en && mem_ready) begin
            n_checks++;
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
                end else begin
                    exp_wr = wr_q.pop_front();
                    if (mem_addr !== exp_wr.addr || mem_wdata !== exp_wr.data) begin
                        n_fail++;
                        $display("FAIL write got %h=%h expected %h=%h",
                                 mem_addr, mem_wdata, exp_wr.addr, exp_wr.data);
                    end
                end
            end else begin
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read addr=%h", mem_addr);
                end else begin
                    exp_rd = rd_q.pop_front();
                    if (mem_addr !== exp_rd) begin
                        n_fail++;
                        $display("FAIL read_addr got %h expected %h", mem_addr, exp_rd);
                    end
                end
            end
        end
        if (!reset && pc_load) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pc_load pc_out=%h", pc_out);
            end else begin
                exp_done = done_q.pop_front();
                if (pc_out !== exp_done.pc || sp_out !== exp_done.sp ||
                    sp_load !== 1'b1 || set_int_disable !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done got pc=%h sp=%h sp_load=%b sid=%b expected pc=%h sp=%h 1 1",
                             pc_out, sp_out, sp_load, set_int_disable, exp_done.pc, exp_done.sp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int nb, output bit seen, output int nsid);
        nb = 0; seen = 1'b0; nsid = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (set_int_disable) nsid++;
            if (pc_load) seen = 1'b1;
        end
        tick();
    endtask

    task automatic push_writes(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp);
        wr_q.push_back({8'h01, sp, pc[15:8]});
        wr_q.push_back({8'h01, sp - 8'd1, pc[7:0]});
        wr_q.push_back({8'h01, sp - 8'd2, p});
    endtask

    task automatic test_reset();
        int nb, nsid; bit seen;
        #2;
        n_checks++;
        if ({busy, mem_en, mem_we, pc_load, sp_load, set_int_disable} !== 6'b0 ||
            mem_addr !== 16'h0 || pc_out !== 16'h0 || sp_out !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b en=%b we=%b addr=%h pc_out=%h sp_out=%h expected zeros",
                     busy, mem_en, mem_we, mem_addr, pc_out, sp_out);
        end
        sp_in = 8'h00;
        rd_q.push_back(16'hFFFC);
        rd_q.push_back(16'hFFFD);
        done_q.push_back({16'h8000, 8'hFD});
        tick();
        reset = 1'b0;
        tick();
        wait_done(20, nb, seen, nsid);
        n_checks++;
        if (!seen || nb != 6) begin
            n_fail++;
            $display("FAIL reset_seq seen=%b busy_cycles=%0d expected 1 6", seen, nb);
        end
    endtask

    task automatic test_irq();
        int nb, nsid; bit seen;
        pc_in = 16'h1234; p_in = 8'h00; sp_in = 8'hFF; irq = 1'b1; irq_mask = 1'b0;
        push_writes(16'h1234, 8'h20, 8'hFF);
        rd_q.push_back(16'hFFFE);
        rd_q.push_back(16'hFFFF);
        done_q.push_back({16'h7856, 8'hFC});
        start = 1'b1;
        tick();
        start = 1'b0; irq = 1'b0;
        wait_done(20, nb, seen, nsid);
        n_checks++;
        if (!seen || nb != 6 || nsid != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_seq seen=%b busy_cycles=%0d sid_pulses=%0d busy_after=%b expected 1 6 1 0",
                     seen, nb, nsid, busy);
        end
    endtask

    task automatic test_brk();
        int nb, nsid; bit seen;
        pc_in = 16'hABCD; p_in = 8'hC3; sp_in = 8'h01; brk_req = 1'b1;
        push_writes(16'hABCD, 8'hF3, 8'h01);
        rd_q.push_back(16'hFFFE);
        rd_q.push_back(16'hFFFF);
        done_q.push_back({16'h7856, 8'hFE});
        start = 1'b1;
        tick();
        start = 1'b0; brk_req = 1'b0;
        wait_done(20, nb, seen, nsid);
        n_checks++;
        if (!seen || nb != 6) begin
            n_fail++;
            $display("FAIL brk_seq seen=%b busy_cycles=%0d expected 1 6", seen, nb);
        end
    endtask

    task automatic test_masked_irq_then_nmi();
        int nb, nsid; bit seen;
        irq = 1'b1; irq_mask = 1'b1;
        #1;
        n_checks++;
        if (int_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_int_pending got %b expected 0", int_pending);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_start_busy got %b expected 0", busy);
        end
        irq = 1'b0; irq_mask = 1'b0; nmi = 1'b1;
        tick();
        n_checks++;
        if (int_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL nmi_edge_pending got %b expected 1", int_pending);
        end
        pc_in = 16'h4000; p_in = 8'h81; sp_in = 8'h80;
        push_writes(16'h4000, 8'hA1, 8'h80);
        rd_q.push_back(16'hFFFA);
        rd_q.push_back(16'hFFFB);
        done_q.push_back({16'h2211, 8'h7D});
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, nb, seen, nsid);
        n_checks++;
        if (!seen || nb != 6 || int_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL nmi_seq seen=%b busy_cycles=%0d int_pending=%b expected 1 6 0",
                     seen, nb, int_pending);
        end
        nmi = 1'b0;
    endtask

    task automatic test_nmi_hijack();
        int nb, nsid; bit seen;
        pc_in = 16'h2345; p_in = 8'h00; sp_in = 8'h50; irq = 1'b1;
        push_writes(16'h2345, 8'h20, 8'h50);
        rd_q.push_back(16'hFFFA);
        rd_q.push_back(16'hFFFB);
        done_q.push_back({16'h2211, 8'h4D});
        start = 1'b1;
        tick();                 // PUSH_PCH
        start = 1'b0; irq = 1'b0;
        tick();                 // PUSH_PCL
        nmi = 1'b1;
        tick();                 // PUSH_P, NMI now pending
        nmi = 1'b0;
        n_checks++;
        if (int_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL hijack_pending got %b expected 1", int_pending);
        end
        tick();                 // VEC_LO
        n_checks++;
        if (int_pending !== 1'b0 || mem_addr !== 16'hFFFA || mem_en !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL hijack_vector int_pending=%b addr=%h en=%b we=%b expected 0 fffa 1 0",
                     int_pending, mem_addr, mem_en, mem_we);
        end
        nmi = 1'b1;
        wait_done(20, nb, seen, nsid);
        n_checks++;
        if (!seen || nb != 3 || int_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL late_nmi seen=%b tail_cycles=%0d int_pending=%b expected 1 3 1",
                     seen, nb, int_pending);
        end
        nmi = 1'b0;
    endtask

    task automatic test_wait_states();
        int nb, nb_tail, nsid; bit seen;
        pc_in = 16'h5A5A; p_in = 8'h0F; sp_in = 8'h10;
        push_writes(16'h5A5A, 8'h2F, 8'h10);
        rd_q.push_back(16'hFFFA);
        rd_q.push_back(16'hFFFB);
        done_q.push_back({16'h2211, 8'h0D});
        nb = 0;
        start = 1'b1;
        tick();                 // PUSH_PCH
        start = 1'b0;
        if (busy) nb++;
        tick();                 // PUSH_PCL, stall begins
        mem_ready = 1'b0;
        if (busy) nb++;
        for (int w = 0; w < 2; w++) begin
            if (w == 1) tick();
            n_checks++;
            if (mem_addr !== 16'h010F || mem_wdata !== 8'h5A || mem_we !== 1'b1 || mem_en !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_hold%0d addr=%h data=%h we=%b en=%b expected 010f 5a 1 1",
                         w, mem_addr, mem_wdata, mem_we, mem_en);
            end
            if (w == 1 && busy) nb++;
        end
        tick();                 // still PUSH_PCL, stall released
        n_checks++;
        if (mem_addr !== 16'h010F || mem_wdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL wait_hold2 addr=%h data=%h expected 010f 5a", mem_addr, mem_wdata);
        end
        mem_ready = 1'b1;
        wait_done(20, nb_tail, seen, nsid);
        n_checks++;
        if (!seen || nb + nb_tail != 8) begin
            n_fail++;
            $display("FAIL wait_seq seen=%b busy_cycles=%0d expected 1 8", seen, nb + nb_tail);
        end
    endtask

    task automatic test_reset_abort();
        int nb, nsid; bit seen;
        pc_in = 16'h1111; p_in = 8'h00; sp_in = 8'h20; irq = 1'b1;
        push_writes(16'h1111, 8'h20, 8'h20);
        rd_q.push_back(16'hFFFE);
        start = 1'b1;
        tick();                 // PUSH_PCH
        start = 1'b0; irq = 1'b0;
        for (int k = 0; k < 4; k++) tick();   // VEC_HI
        n_checks++;
        if (mem_addr !== 16'hFFFF || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup addr=%h busy=%b expected ffff 1", mem_addr, busy);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, mem_en, mem_we, pc_load, sp_load, set_int_disable} !== 6'b0 || mem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_outputs busy=%b en=%b we=%b pc_load=%b addr=%h expected zeros",
                     busy, mem_en, mem_we, pc_load, mem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (pc_load !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_hold pc_load=%b busy=%b expected 0 0", pc_load, busy);
            end
        end
        tick();
        rd_q.push_back(16'hFFFC);
        rd_q.push_back(16'hFFFD);
        done_q.push_back({16'h8000, 8'h1D});
        reset = 1'b0;
        tick();
        wait_done(20, nb, seen, nsid);
        n_checks++;
        if (!seen || nb != 6) begin
            n_fail++;
            $display("FAIL post_abort_reset seen=%b busy_cycles=%0d expected 1 6", seen, nb);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'hFFFA] = 8'h11; mem[16'hFFFB] = 8'h22;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'hFFFE] = 8'h56; mem[16'hFFFF] = 8'h78;
        reset = 1'b1; start = 1'b0; nmi = 1'b0; irq = 1'b0; irq_mask = 1'b0; brk_req = 1'b0;
        pc_in = '0; p_in = 8'h00; sp_in = 8'h00; mem_ready = 1'b1;

        test_reset();
        test_irq();
        test_brk();
        test_masked_irq_then_nmi();
        test_nmi_hijack();
        test_wait_states();
        test_reset_abort();

        n_checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover writes=%0d reads=%0d dones=%0d expected 0 0 0",
                     wr_q.size(), rd_q.size(), done_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
